keyed_lock_shell: RTL and testbench
===================================

// Module: keyed_lock_shell
// PURPOSE
// Parametrised key-gated wrapper for obfuscated benchmark cores (c432-class and larger). XOR key gates
// sit on every primary input and output, and N_LUT key-programmable 4:1 mux sites stand in for core gates.
// A serially loaded, double-buffered key register with commit handshake feeds them, and the core sits
// inside a 2-stage valid/ready pipeline. The oracle and attack benches drive it over the streaming interface.
// PARAMETERS
// N_IN   36  primary inputs of wrapped core (XOR key bit per input)
// N_OUT  7   primary outputs of wrapped core (XOR key bit per output)
// N_LUT  1   mux4 LUT sites; 4 key bits each
// KEY_W  localparam = N_IN + N_OUT + 4*N_LUT; key layout LSB-first: [in mask | out mask | LUT0..LUTn]
// PORTS
// clk        in   1      clock
// rst        in   1      asynchronous active-high reset
// key_sdi    in   1      serial key bit
// key_shift  in   1      shift key_sdi into shadow register this cycle
// key_commit in   1      request shadow->active copy (1-cycle pulse)
// key_ready  out  1      active key valid; block ARMED
// key_err    out  1      sticky: commit with wrong bit count; cleared by next good commit
// in_data    in   N_IN   keyed (obfuscated) input vector
// in_valid   in   1      in_data valid
// in_ready   out  1      stage-1 can accept
// core_in    out  N_IN   registered in_data ^ in_mask, to combinational core
// core_out   in   N_OUT  core result (combinational from core_in and lut_y)
// lut_a      in   N_LUT  LUT select MSB per site (from core)
// lut_b      in   N_LUT  LUT select LSB per site (from core)
// lut_y      out  N_LUT  lut_y[j] = active LUT_j key[{lut_a[j],lut_b[j]}], combinational
// out_data   out  N_OUT  registered core_out ^ out_mask
// out_valid  out  1      out_data valid
// out_ready  in   1      downstream accepts
// BEHAVIOUR
// - Reset: state NOKEY, shadow/active key=0, bit count=0, key_ready=0, key_err=0, both stages empty,
//   core_in=0, out_data=0, out_valid=0, in_ready=0.
// - FSM NOKEY -> ARMED on good commit. ARMED -> DRAIN on commit request with pipeline non-empty.
//   DRAIN -> ARMED when both stages empty; the copy happens on that same cycle. ARMED -> ARMED on
//   a good commit with an empty pipeline; the copy is immediate. A bad commit changes no state.
// - Shift: shadow <= {key_sdi, shadow[KEY_W-1:1]}. After KEY_W shifts the first bit sits at bit 0.
//   Bit count increments and saturates at KEY_W+1. Shifting is allowed in every state; active key is
//   untouched until commit.
// - Commit is good iff count==KEY_W. It copies shadow->active, resets count to 0 and clears key_err.
//   A bad commit sets key_err, resets count to 0 and keeps the active key.
//   key_shift and key_commit in the same cycle: the shift is ignored; commit sees the pre-cycle shadow.
// - in_ready = key_ready & state!=DRAIN & (stage1 empty | stage1 advancing). key_ready=1 in ARMED and DRAIN.
// - Pipeline: on in_valid&in_ready, core_in <= in_data ^ in_mask (stage1 full).
//   Stage1 advances to stage2 when stage2 is empty or out_ready. It then captures out_data <= core_out ^ out_mask.
//   Latency in_valid->out_valid = 2 cycles, throughput 1/cycle, no bubbles under out_ready=1.
// - out_valid is held with out_data stable until out_ready. No drop, no duplicate.
// - Masks used by a transaction are those active when it enters each stage. Commit waits for drain,
//   so a transaction never mixes keys.
// - Async reset mid-transaction discards in-flight data and the key (re-load required).
// STRUCTURE
// - Package lock_pkg: fsm_state_e {NOKEY, ARMED, DRAIN}, key-field offset functions (in/out/LUT base from params).
// - Sub-module key_shift_reg (shadow + count + commit qualify, outputs active key, key_err).
// - Top holds FSM, 2-stage pipeline, XOR masks, LUT mux.
// TESTING (N_IN=4, N_OUT=2, N_LUT=1, KEY_W=10)
// 1 Reset -> key_ready=0, in_ready=0, out_valid=0. Drive in_valid=1 for 5 cycles -> nothing accepted.
// 2 Shift 10 bits with in_mask=4'b1010, out_mask=2'b01, LUT=4'b0110, then commit -> key_ready=1, key_err=0.
//   lut_a,b=1,0 -> lut_y=1; 1,1 -> 0.
// 3 ARMED, stub core_out=core_in[1:0]; send in_data=4'b0011, out_ready=1.
//   core_in=4'b1001 one cycle later; out_data=2'b00 with out_valid two cycles after accept.
//   A back-to-back stream of 8 inputs yields 8 outputs in order.
// 4 Shift 9 bits + commit -> key_err=1, active key unchanged (case 3 result repeats).
//   Then 10 bits + commit -> key_err=0.
// 5 Hold out_ready=0 with 2 transactions in flight and commit new key -> DRAIN, in_ready=0.
//   Release out_ready -> both outputs use old out_mask, then new key active, in_ready=1.
// 6 Assert rst mid-stream -> out_valid=0 immediately, key_ready=0; no stale output after rst falls.

Source files
------------

// File: rtl/keyed_lock_shell_pkg.sv
// Shared types and key-layout helpers for the keyed lock shell.
// Key layout, LSB first: [input mask | output mask | LUT0 .. LUTn].
package lock_pkg;

    typedef enum logic [1:0] {
        StNoKey = 2'd0,
        StArmed = 2'd1,
        StDrain = 2'd2
    } fsm_state_e;

    function automatic int unsigned key_width(input int unsigned n_in,
                                              input int unsigned n_out,
                                              input int unsigned n_lut);
        return n_in + n_out + 4 * n_lut;
    endfunction

    function automatic int unsigned in_base();
        return 0;
    endfunction

    function automatic int unsigned out_base(input int unsigned n_in);
        return n_in;
    endfunction

    function automatic int unsigned lut_base(input int unsigned n_in,
                                             input int unsigned n_out,
                                             input int unsigned j);
        return n_in + n_out + 4 * j;
    endfunction

endpackage

// File: rtl/keyed_lock_shell_if.sv
// Streaming valid/ready interface between the oracle/attack bench and the lock shell.
interface keyed_lock_shell_if #(
    parameter int unsigned N_IN  = 36,
    parameter int unsigned N_OUT = 7
);
    logic [N_IN-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [N_OUT-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/keyed_lock_shell_key_shift_reg.sv
// Serial shadow key register with bit counter, commit qualification and active-key copy.
// The copy strobe comes from the top FSM so a commit can be deferred until the pipeline drains.
module key_shift_reg #(
    parameter int unsigned KEY_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdi_i,
    input  logic             shift_i,
    input  logic             commit_i,
    input  logic             copy_i,
    output logic             good_o,
    output logic [KEY_W-1:0] active_o,
    output logic             err_o
);
    localparam int unsigned CNT_W = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] CntSat  = CNT_W'(KEY_W + 1);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign good_o   = commit_i && (cnt_q == CntFull);
    assign active_o = active_q;
    assign err_o    = err_q;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        // A commit in the same cycle as a shift wins; the shift is dropped.
        if (commit_i) begin
            cnt_d = '0;
            err_d = !good_o;
        end else if (shift_i) begin
            shadow_d = {sdi_i, shadow_q[KEY_W-1:1]};
            if (cnt_q != CntSat) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (copy_i) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: rtl/keyed_lock_shell.sv
// Key-gated wrapper: XOR masks on core inputs/outputs, key-programmed mux4 LUT sites,
// and a 2-stage valid/ready pipeline around an external combinational core.
module keyed_lock_shell
    import lock_pkg::*;
#(
    parameter int unsigned N_IN  = 36,
    parameter int unsigned N_OUT = 7,
    parameter int unsigned N_LUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_sdi_i,
    input  logic             key_shift_i,
    input  logic             key_commit_i,
    output logic             key_ready_o,
    output logic             key_err_o,
    output logic [N_IN-1:0]  core_in_o,
    input  logic [N_OUT-1:0] core_out_i,
    input  logic [N_LUT-1:0] lut_a_i,
    input  logic [N_LUT-1:0] lut_b_i,
    output logic [N_LUT-1:0] lut_y_o,
    keyed_lock_shell_if.slave strm
);
    localparam int unsigned KEY_W = key_width(N_IN, N_OUT, N_LUT);

    logic [KEY_W-1:0] active_key;
    logic             commit_good;
    logic             key_copy;
    logic [N_IN-1:0]  in_mask;
    logic [N_OUT-1:0] out_mask;

    fsm_state_e       st_q, st_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [N_IN-1:0]  core_in_q, core_in_d;
    logic [N_OUT-1:0] out_data_q, out_data_d;
    logic             pipe_empty;
    logic             s1_adv;
    logic             in_ready;
    logic             accept;

    key_shift_reg #(
        .KEY_W (KEY_W)
    ) u_key (
        .clk      (clk),
        .rst      (rst),
        .sdi_i    (key_sdi_i),
        .shift_i  (key_shift_i),
        .commit_i (key_commit_i),
        .copy_i   (key_copy),
        .good_o   (commit_good),
        .active_o (active_key),
        .err_o    (key_err_o)
    );

    assign in_mask  = active_key[in_base() +: N_IN];
    assign out_mask = active_key[out_base(N_IN) +: N_OUT];

    for (genvar j = 0; j < N_LUT; j++) begin : g_lut
        logic [3:0] lut_key;
        assign lut_key    = active_key[lut_base(N_IN, N_OUT, j) +: 4];
        assign lut_y_o[j] = lut_key[{lut_a_i[j], lut_b_i[j]}];
    end

    assign pipe_empty  = !s1_q && !s2_q;
    assign key_ready_o = (st_q != StNoKey);
    assign s1_adv      = s1_q && (!s2_q || strm.out_ready);
    assign in_ready    = key_ready_o && (st_q != StDrain) && (!s1_q || s1_adv);
    assign accept      = strm.in_valid && in_ready;

    // A good commit with data in flight parks in DRAIN; the copy fires once both stages empty.
    always_comb begin
        st_d     = st_q;
        key_copy = 1'b0;
        unique case (st_q)
            StNoKey: begin
                if (commit_good) begin
                    st_d     = StArmed;
                    key_copy = 1'b1;
                end
            end
            StArmed: begin
                if (commit_good) begin
                    if (pipe_empty) begin
                        key_copy = 1'b1;
                    end else begin
                        st_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    st_d     = StArmed;
                    key_copy = 1'b1;
                end
            end
            default: st_d = StNoKey;
        endcase
    end

    always_comb begin
        s1_d       = s1_q;
        s2_d       = s2_q;
        core_in_d  = core_in_q;
        out_data_d = out_data_q;
        if (accept) begin
            s1_d      = 1'b1;
            core_in_d = strm.in_data ^ in_mask;
        end else if (s1_adv) begin
            s1_d = 1'b0;
        end
        if (s1_adv) begin
            s2_d       = 1'b1;
            out_data_d = core_out_i ^ out_mask;
        end else if (strm.out_ready) begin
            s2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= StNoKey;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            core_in_q  <= '0;
            out_data_q <= '0;
        end else begin
            st_q       <= st_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            core_in_q  <= core_in_d;
            out_data_q <= out_data_d;
        end
    end

    assign core_in_o      = core_in_q;
    assign strm.in_ready  = in_ready;
    assign strm.out_data  = out_data_q;
    assign strm.out_valid = s2_q;
endmodule

// File: tb/tb_keyed_lock_shell.sv
// Directed bench for keyed_lock_shell at N_IN=4, N_OUT=2, N_LUT=1 with a pass-through stub core.
module tb_keyed_lock_shell;
    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 2;
    localparam int unsigned N_LUT = 1;

    // {LUT, out_mask, in_mask}
    localparam logic [9:0] K1   = {4'b0110, 2'b01, 4'b1010};
    localparam logic [9:0] K2   = {4'b1001, 2'b10, 4'b0101};
    localparam logic [9:0] KBAD = 10'b1100110011;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_sdi = 1'b0;
    logic             key_shift = 1'b0;
    logic             key_commit = 1'b0;
    logic             key_ready;
    logic             key_err;
    logic [N_IN-1:0]  core_in;
    logic [N_OUT-1:0] core_out;
    logic [N_LUT-1:0] lut_a = '0;
    logic [N_LUT-1:0] lut_b = '0;
    logic [N_LUT-1:0] lut_y;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keyed_lock_shell_if #(.N_IN(N_IN), .N_OUT(N_OUT)) strm ();

    assign core_out = core_in[1:0];

    keyed_lock_shell #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .N_LUT (N_LUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_sdi_i    (key_sdi),
        .key_shift_i  (key_shift),
        .key_commit_i (key_commit),
        .key_ready_o  (key_ready),
        .key_err_o    (key_err),
        .core_in_o    (core_in),
        .core_out_i   (core_out),
        .lut_a_i      (lut_a),
        .lut_b_i      (lut_b),
        .lut_y_o      (lut_y),
        .strm         (strm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_key(input logic [9:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            key_shift = 1'b1;
            key_sdi   = k[i];
            tick();
        end
        key_shift = 1'b0;
        key_sdi   = 1'b0;
    endtask

    task automatic commit();
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
    endtask

    task automatic single_txn(input string tag, input logic [3:0] d,
                              input logic [3:0] exp_core, input logic [1:0] exp_out);
        strm.out_ready = 1'b1;
        strm.in_valid  = 1'b1;
        strm.in_data   = d;
        #1;
        chk({tag, "_in_ready"}, 32'(strm.in_ready), 32'd1);
        tick();
        strm.in_valid = 1'b0;
        chk({tag, "_core_in"}, 32'(core_in), 32'(exp_core));
        chk({tag, "_early_valid"}, 32'(strm.out_valid), 32'd0);
        tick();
        chk({tag, "_out_valid"}, 32'(strm.out_valid), 32'd1);
        chk({tag, "_out_data"}, 32'(strm.out_data), 32'(exp_out));
        tick();
        chk({tag, "_out_drop"}, 32'(strm.out_valid), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_q[$];
        logic [3:0] xd;
        int         sent;
        int         got;
        int         cycles;
        logic       acc;

        strm.in_valid  = 1'b0;
        strm.in_data   = '0;
        strm.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state, no acceptance without a key
        chk("rst_key_ready", 32'(key_ready), 32'd0);
        chk("rst_key_err", 32'(key_err), 32'd0);
        chk("rst_in_ready", 32'(strm.in_ready), 32'd0);
        chk("rst_out_valid", 32'(strm.out_valid), 32'd0);
        chk("rst_out_data", 32'(strm.out_data), 32'd0);
        strm.in_valid = 1'b1;
        strm.in_data  = 4'hF;
        strm.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nokey_in_ready", 32'(strm.in_ready), 32'd0);
        end
        strm.in_valid = 1'b0;
        chk("nokey_core_in", 32'(core_in), 32'd0);
        chk("nokey_out_valid", 32'(strm.out_valid), 32'd0);

        // 2: load K1 and commit
        shift_key(K1, 10);
        chk("pre_commit_ready", 32'(key_ready), 32'd0);
        commit();
        chk("k1_key_ready", 32'(key_ready), 32'd1);
        chk("k1_key_err", 32'(key_err), 32'd0);
        lut_a = 1'b1; lut_b = 1'b0; #1;
        chk("k1_lut_10", 32'(lut_y), 32'd1);
        lut_b = 1'b1; #1;
        chk("k1_lut_11", 32'(lut_y), 32'd0);

        // 3: single transaction then 8-deep back-to-back stream
        single_txn("t3", 4'b0011, 4'b1001, 2'b00);
        sent   = 0;
        got    = 0;
        cycles = 0;
        strm.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xd = 4'(i) ^ 4'b1010;
            exp_q.push_back(xd[1:0] ^ 2'b01);
        end
        while (got < 8 && cycles < 30) begin
            strm.in_valid = (sent < 8);
            strm.in_data  = 4'(sent);
            #1;
            acc = strm.in_valid && strm.in_ready;
            if (strm.out_valid) begin
                chk("stream_data", 32'(strm.out_data), 32'(exp_q.pop_front()));
                got++;
            end
            tick();
            if (acc) sent++;
            cycles++;
        end
        strm.in_valid = 1'b0;
        chk("stream_count", 32'(got), 32'd8);
        chk("stream_cycles", 32'(cycles), 32'd10);

        // 4: short key rejected, active key kept; then a full load clears the error
        shift_key(KBAD, 9);
        commit();
        chk("bad_key_err", 32'(key_err), 32'd1);
        chk("bad_key_ready", 32'(key_ready), 32'd1);
        single_txn("t4", 4'b0011, 4'b1001, 2'b00);
        chk("bad_err_sticky", 32'(key_err), 32'd1);
        shift_key(K1, 10);
        commit();
        chk("good_clears_err", 32'(key_err), 32'd0);

        // 5: commit K2 with two transactions stalled in the pipe
        shift_key(K2, 10);
        strm.out_ready = 1'b0;
        strm.in_valid  = 1'b1;
        strm.in_data   = 4'b0011;
        tick();
        strm.in_data   = 4'b0110;
        tick();
        strm.in_valid  = 1'b0;
        chk("stall_out_valid", 32'(strm.out_valid), 32'd1);
        chk("stall_in_ready", 32'(strm.in_ready), 32'd0);
        commit();
        chk("drain_key_ready", 32'(key_ready), 32'd1);
        chk("drain_hold_data", 32'(strm.out_data), 32'd0);
        strm.out_ready = 1'b1;
        #1;
        chk("drain_in_ready", 32'(strm.in_ready), 32'd0);
        tick();
        chk("drain_second_valid", 32'(strm.out_valid), 32'd1);
        chk("drain_second_data", 32'(strm.out_data), 32'd1);
        chk("drain_in_ready2", 32'(strm.in_ready), 32'd0);
        tick();
        chk("drain_empty_valid", 32'(strm.out_valid), 32'd0);
        chk("drain_copy_cycle", 32'(strm.in_ready), 32'd0);
        tick();
        chk("k2_in_ready", 32'(strm.in_ready), 32'd1);
        lut_a = 1'b0; lut_b = 1'b0; #1;
        chk("k2_lut_00", 32'(lut_y), 32'd1);
        lut_b = 1'b1; #1;
        chk("k2_lut_01", 32'(lut_y), 32'd0);
        single_txn("t5", 4'b0000, 4'b0101, 2'b11);

        // 6: asynchronous reset with data in flight
        strm.in_valid = 1'b1;
        strm.in_data  = 4'b0001;
        tick();
        tick();
        chk("pre_rst_valid", 32'(strm.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(strm.out_valid), 32'd0);
        chk("arst_key_ready", 32'(key_ready), 32'd0);
        chk("arst_core_in", 32'(core_in), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", 32'(strm.out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(strm.in_ready), 32'd0);
        end
        strm.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
